// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-port unified memory between instruction fetch and data access.
// Data requests take priority; each access runs MEM_LAT busy cycles followed by one done cycle.
module unified_mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          IReqF,
  input  logic [AW-1:0] IAddrF,
  output logic [DW-1:0] IRdataF,
  output logic          IStallF,
  input  logic          DReqM,
  input  logic          DWeM,
  input  logic [AW-1:0] DAddrM,
  input  logic [DW-1:0] DWdataM,
  output logic [DW-1:0] DRdataM,
  output logic          DStallM,
  output logic          MemStart,
  output logic [AW-1:0] MemAddr,
  output logic          MemWe,
  output logic [DW-1:0] MemWdata,
  input  logic [DW-1:0] MemRdata
);

  localparam int              CW        = $clog2(MEM_LAT + 1);
  localparam logic [CW-1:0]   CNT_FIRST = CW'(MEM_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_IBUSY,
    S_DBUSY,
    S_IDONE,
    S_DDONE
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic [AW-1:0] r_addr;
  logic          r_we;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_irdata;
  logic [DW-1:0] r_drdata;
  logic          w_start_i;
  logic          w_start_d;
  logic          w_busy;
  logic          w_last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_start_i = 1'b0;
    w_start_d = 1'b0;
    w_busy    = (r_state == S_IBUSY) || (r_state == S_DBUSY);
    w_last    = w_busy && (r_cnt == '0);
    case (r_state)
      S_IDLE: begin
        if (DReqM) begin
          w_next    = S_DBUSY;
          w_start_d = 1'b1;
        end else if (IReqF) begin
          w_next    = S_IBUSY;
          w_start_i = 1'b1;
        end
      end
      S_IBUSY: if (w_last) w_next = S_IDONE;
      S_DBUSY: if (w_last) w_next = S_DDONE;
      S_IDONE,
      S_DDONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_start_i || w_start_d) begin
      r_cnt <= CNT_FIRST;
    end else if (w_busy && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  // Write enable is cleared on the last busy cycle so it never leaks into DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr   <= '0;
      r_we     <= 1'b0;
      r_wdata  <= '0;
      r_irdata <= '0;
      r_drdata <= '0;
    end else begin
      if (w_start_i) begin
        r_addr <= IAddrF;
        r_we   <= 1'b0;
      end
      if (w_start_d) begin
        r_addr  <= DAddrM;
        r_we    <= DWeM;
        r_wdata <= DWdataM;
      end
      if (w_last) begin
        r_we <= 1'b0;
        if (r_state == S_IBUSY) r_irdata <= MemRdata;
        if ((r_state == S_DBUSY) && !r_we) r_drdata <= MemRdata;
      end
    end
  end

  assign MemStart = w_busy && (r_cnt == CNT_FIRST);
  assign MemAddr  = r_addr;
  assign MemWe    = r_we;
  assign MemWdata = r_wdata;
  assign IRdataF  = r_irdata;
  assign DRdataM  = r_drdata;
  assign IStallF  = IReqF && (r_state != S_IDONE);
  assign DStallM  = DReqM && (r_state != S_DDONE);

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: directed scenarios plus randomized traffic on MEM_LAT=2 and
// MEM_LAT=1 instances, checked against a transaction-timing model.
module tb_unified_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        IReqF, DReqM, DWeM;
  logic [31:0] IAddrF, DAddrM, DWdataM, MemRdata;

  logic [31:0] irdata[2], drdata[2], maddr[2], mwdata[2];
  logic        istall[2], dstall[2], mstart[2], mwe[2];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  unified_mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(2)) u_dut_l2 (
    .clk(clk), .reset(reset),
    .IReqF(IReqF), .IAddrF(IAddrF), .IRdataF(irdata[0]), .IStallF(istall[0]),
    .DReqM(DReqM), .DWeM(DWeM), .DAddrM(DAddrM), .DWdataM(DWdataM),
    .DRdataM(drdata[0]), .DStallM(dstall[0]),
    .MemStart(mstart[0]), .MemAddr(maddr[0]), .MemWe(mwe[0]), .MemWdata(mwdata[0]),
    .MemRdata(MemRdata)
  );

  unified_mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(1)) u_dut_l1 (
    .clk(clk), .reset(reset),
    .IReqF(IReqF), .IAddrF(IAddrF), .IRdataF(irdata[1]), .IStallF(istall[1]),
    .DReqM(DReqM), .DWeM(DWeM), .DAddrM(DAddrM), .DWdataM(DWdataM),
    .DRdataM(drdata[1]), .DStallM(dstall[1]),
    .MemStart(mstart[1]), .MemAddr(maddr[1]), .MemWe(mwe[1]), .MemWdata(mwdata[1]),
    .MemRdata(MemRdata)
  );

  task automatic clear_inputs();
    IReqF = 1'b0; IAddrF = '0; DReqM = 1'b0; DWeM = 1'b0;
    DAddrM = '0; DWdataM = '0; MemRdata = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    @(negedge clk);
    #1;
    for (int l = 0; l < 2; l++) begin
      checks++;
      if ({irdata[l], drdata[l]} !== 64'h0) begin
        errors++;
        $display("FAIL reset_rdata lane=%0d got=%h/%h exp=0/0", l, irdata[l], drdata[l]);
      end
      checks++;
      if ({maddr[l], mwdata[l]} !== 64'h0) begin
        errors++;
        $display("FAIL reset_mem lane=%0d got=%h/%h exp=0/0", l, maddr[l], mwdata[l]);
      end
      checks++;
      if ({mwe[l], mstart[l], istall[l], dstall[l]} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_ctl lane=%0d got=%b%b%b%b exp=0000", l, mwe[l], mstart[l],
                 istall[l], dstall[l]);
      end
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_fetch();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 0) begin IReqF = 1'b1; IAddrF = 32'h10; MemRdata = 32'hE3A00001; end
      #1;
      checks++;
      if (istall[0] !== logic'(c < 3)) begin
        errors++; $display("FAIL t1_istall c=%0d got=%b exp=%b", c, istall[0], c < 3);
      end
      checks++;
      if (mstart[0] !== logic'(c == 1)) begin
        errors++; $display("FAIL t1_memstart c=%0d got=%b exp=%b", c, mstart[0], c == 1);
      end
      if (c == 1 || c == 2) begin
        checks++;
        if (maddr[0] !== 32'h10 || mwe[0] !== 1'b0) begin
          errors++; $display("FAIL t1_addr_we c=%0d got=%h/%b exp=10/0", c, maddr[0], mwe[0]);
        end
      end
      if (c == 3) begin
        checks++;
        if (irdata[0] !== 32'hE3A00001) begin
          errors++; $display("FAIL t1_irdata got=%h exp=e3a00001", irdata[0]);
        end
      end
    end
  endtask

  task automatic test_priority();
    do_reset();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 0) begin
        IReqF = 1'b1; IAddrF = 32'h20;
        DReqM = 1'b1; DWeM = 1'b0; DAddrM = 32'h80; MemRdata = 32'h12345678;
      end
      if (c == 4) begin DReqM = 1'b0; MemRdata = 32'h0A0B0C0D; end
      #1;
      checks++;
      if (dstall[0] !== logic'(c < 3)) begin
        errors++; $display("FAIL t2_dstall c=%0d got=%b exp=%b", c, dstall[0], c < 3);
      end
      checks++;
      if (istall[0] !== logic'(c < 7)) begin
        errors++; $display("FAIL t2_istall c=%0d got=%b exp=%b", c, istall[0], c < 7);
      end
      checks++;
      if (mstart[0] !== logic'(c == 1 || c == 5)) begin
        errors++; $display("FAIL t2_memstart c=%0d got=%b", c, mstart[0]);
      end
      if (c == 1 || c == 2) begin
        checks++;
        if (maddr[0] !== 32'h80) begin
          errors++; $display("FAIL t2_daddr c=%0d got=%h exp=80", c, maddr[0]);
        end
      end
      if (c == 5 || c == 6) begin
        checks++;
        if (maddr[0] !== 32'h20 || mwe[0] !== 1'b0) begin
          errors++; $display("FAIL t2_iaddr c=%0d got=%h/%b exp=20/0", c, maddr[0], mwe[0]);
        end
      end
      if (c == 3) begin
        checks++;
        if (drdata[0] !== 32'h12345678) begin
          errors++; $display("FAIL t2_drdata got=%h exp=12345678", drdata[0]);
        end
      end
      if (c == 7) begin
        checks++;
        if (irdata[0] !== 32'h0A0B0C0D) begin
          errors++; $display("FAIL t2_irdata got=%h exp=0a0b0c0d", irdata[0]);
        end
      end
    end
  endtask

  // Runs straight after test_priority so DRdataM holds a load result a store must not disturb.
  task automatic test_store();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 0) begin
        IReqF = 1'b0; DReqM = 1'b1; DWeM = 1'b1; DAddrM = 32'h84;
        DWdataM = 32'hDEADBEEF; MemRdata = 32'hBAD0BAD0;
      end
      if (c == 4) begin DReqM = 1'b0; DWeM = 1'b0; end
      #1;
      checks++;
      if (mwe[0] !== logic'(c == 1 || c == 2)) begin
        errors++; $display("FAIL t3_memwe c=%0d got=%b", c, mwe[0]);
      end
      checks++;
      if (mstart[0] !== logic'(c == 1)) begin
        errors++; $display("FAIL t3_memstart c=%0d got=%b", c, mstart[0]);
      end
      if (c == 1 || c == 2) begin
        checks++;
        if (mwdata[0] !== 32'hDEADBEEF || maddr[0] !== 32'h84) begin
          errors++; $display("FAIL t3_wdata c=%0d got=%h/%h exp=deadbeef/84", c, mwdata[0], maddr[0]);
        end
      end
      checks++;
      if (drdata[0] !== 32'h12345678) begin
        errors++; $display("FAIL t3_drdata_kept c=%0d got=%h exp=12345678", c, drdata[0]);
      end
      checks++;
      if (dstall[0] !== logic'(c < 3)) begin
        errors++; $display("FAIL t3_dstall c=%0d got=%b exp=%b", c, dstall[0], c < 3);
      end
    end
  endtask

  task automatic test_no_preempt();
    do_reset();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 0) begin IReqF = 1'b1; IAddrF = 32'h30; MemRdata = 32'h11112222; end
      if (c == 1) begin DReqM = 1'b1; DWeM = 1'b0; DAddrM = 32'h90; end
      if (c == 4) MemRdata = 32'h33334444;
      #1;
      checks++;
      if (istall[0] !== logic'(c != 3)) begin
        errors++; $display("FAIL t4_istall c=%0d got=%b exp=%b", c, istall[0], c != 3);
      end
      checks++;
      if (dstall[0] !== logic'(c >= 1 && c < 7)) begin
        errors++; $display("FAIL t4_dstall c=%0d got=%b", c, dstall[0]);
      end
      checks++;
      if (mstart[0] !== logic'(c == 1 || c == 5)) begin
        errors++; $display("FAIL t4_memstart c=%0d got=%b", c, mstart[0]);
      end
      if (c == 3) begin
        checks++;
        if (irdata[0] !== 32'h11112222) begin
          errors++; $display("FAIL t4_irdata got=%h exp=11112222", irdata[0]);
        end
      end
      if (c == 5 || c == 6) begin
        checks++;
        if (maddr[0] !== 32'h90) begin
          errors++; $display("FAIL t4_daddr c=%0d got=%h exp=90", c, maddr[0]);
        end
      end
      if (c == 7) begin
        checks++;
        if (drdata[0] !== 32'h33334444) begin
          errors++; $display("FAIL t4_drdata got=%h exp=33334444", drdata[0]);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (c == 0) begin DReqM = 1'b1; DWeM = 1'b0; DAddrM = 32'hA0; MemRdata = 32'h77; end
      if (c == 3) reset = 1'b0;
      #1;
      if (c == 1 || c == 4) begin
        checks++;
        if (mstart[0] !== 1'b1 || maddr[0] !== 32'hA0) begin
          errors++; $display("FAIL t5_start c=%0d got=%b/%h exp=1/a0", c, mstart[0], maddr[0]);
        end
      end
      if (c == 2) begin
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({maddr[0], drdata[0], mwdata[0]} !== 96'h0 || mwe[0] !== 1'b0 || mstart[0] !== 1'b0) begin
          errors++; $display("FAIL t5_async_clear got=%h/%b/%b exp=0/0/0", maddr[0], mwe[0], mstart[0]);
        end
      end
      if (c == 2 || c == 3 || c == 5) begin
        checks++;
        if (dstall[0] !== 1'b1) begin
          errors++; $display("FAIL t5_dstall_hold c=%0d got=%b exp=1", c, dstall[0]);
        end
      end
      if (c == 3) begin
        checks++;
        if (mstart[0] !== 1'b0) begin
          errors++; $display("FAIL t5_idle_after_reset got=%b exp=0", mstart[0]);
        end
      end
      if (c == 6) begin
        checks++;
        if (dstall[0] !== 1'b0 || drdata[0] !== 32'h77) begin
          errors++; $display("FAIL t5_done got=%b/%h exp=0/77", dstall[0], drdata[0]);
        end
      end
    end
  endtask

  task automatic test_lat1();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (c == 0) begin IReqF = 1'b1; IAddrF = 32'h44; MemRdata = 32'hCAFEF00D; end
      #1;
      checks++;
      if (istall[1] !== logic'(c < 2)) begin
        errors++; $display("FAIL t6_istall c=%0d got=%b exp=%b", c, istall[1], c < 2);
      end
      checks++;
      if (mstart[1] !== logic'(c == 1)) begin
        errors++; $display("FAIL t6_memstart c=%0d got=%b", c, mstart[1]);
      end
      if (c == 1) begin
        checks++;
        if (maddr[1] !== 32'h44) begin
          errors++; $display("FAIL t6_addr got=%h exp=44", maddr[1]);
        end
      end
      if (c == 2) begin
        checks++;
        if (irdata[1] !== 32'hCAFEF00D) begin
          errors++; $display("FAIL t6_irdata got=%h exp=cafef00d", irdata[1]);
        end
      end
    end
  endtask

  // Model: an access accepted in idle cycle s occupies cycles s+1..s+L and completes in s+L+1.
  task automatic test_random();
    int          lat[2];
    bit          m_act[2], m_isd[2], m_we[2];
    int          m_s[2];
    logic [31:0] m_addr[2], m_wdata[2], m_ir[2], m_dr[2];
    int          k;
    bit          busy, done;
    logic        e;
    lat = '{2, 1};
    do_reset();
    for (int l = 0; l < 2; l++) begin
      m_act[l] = 0; m_isd[l] = 0; m_we[l] = 0; m_s[l] = 0;
      m_addr[l] = '0; m_wdata[l] = '0; m_ir[l] = '0; m_dr[l] = '0;
    end
    for (int t = 0; t < 1500; t++) begin
      @(negedge clk);
      IReqF    = ($urandom_range(0, 9) < 7);
      DReqM    = ($urandom_range(0, 9) < 3);
      DWeM     = $urandom_range(0, 1);
      IAddrF   = $urandom;
      DAddrM   = $urandom;
      DWdataM  = $urandom;
      MemRdata = $urandom;
      #1;
      for (int l = 0; l < 2; l++) begin
        k    = t - m_s[l];
        busy = m_act[l] && k >= 1 && k <= lat[l];
        done = m_act[l] && k == lat[l] + 1;
        e = IReqF && !(done && !m_isd[l]);
        checks++;
        if (istall[l] !== e) begin
          errors++; $display("FAIL rnd_istall lane=%0d t=%0d got=%b exp=%b", l, t, istall[l], e);
        end
        e = DReqM && !(done && m_isd[l]);
        checks++;
        if (dstall[l] !== e) begin
          errors++; $display("FAIL rnd_dstall lane=%0d t=%0d got=%b exp=%b", l, t, dstall[l], e);
        end
        e = busy && k == 1;
        checks++;
        if (mstart[l] !== e) begin
          errors++; $display("FAIL rnd_memstart lane=%0d t=%0d got=%b exp=%b", l, t, mstart[l], e);
        end
        e = busy && m_isd[l] && m_we[l];
        checks++;
        if (mwe[l] !== e) begin
          errors++; $display("FAIL rnd_memwe lane=%0d t=%0d got=%b exp=%b", l, t, mwe[l], e);
        end
        if (busy) begin
          checks++;
          if (maddr[l] !== m_addr[l]) begin
            errors++; $display("FAIL rnd_memaddr lane=%0d t=%0d got=%h exp=%h", l, t, maddr[l], m_addr[l]);
          end
          if (m_isd[l] && m_we[l]) begin
            checks++;
            if (mwdata[l] !== m_wdata[l]) begin
              errors++; $display("FAIL rnd_wdata lane=%0d t=%0d got=%h exp=%h", l, t, mwdata[l], m_wdata[l]);
            end
          end
        end
        checks++;
        if (irdata[l] !== m_ir[l]) begin
          errors++; $display("FAIL rnd_irdata lane=%0d t=%0d got=%h exp=%h", l, t, irdata[l], m_ir[l]);
        end
        checks++;
        if (drdata[l] !== m_dr[l]) begin
          errors++; $display("FAIL rnd_drdata lane=%0d t=%0d got=%h exp=%h", l, t, drdata[l], m_dr[l]);
        end
        if (busy && k == lat[l]) begin
          if (!m_isd[l])     m_ir[l] = MemRdata;
          else if (!m_we[l]) m_dr[l] = MemRdata;
        end
        if (done) begin
          m_act[l] = 0;
        end else if (!m_act[l]) begin
          if (DReqM) begin
            m_act[l] = 1; m_isd[l] = 1; m_we[l] = DWeM; m_s[l] = t;
            m_addr[l] = DAddrM; m_wdata[l] = DWdataM;
          end else if (IReqF) begin
            m_act[l] = 1; m_isd[l] = 0; m_we[l] = 0; m_s[l] = t;
            m_addr[l] = IAddrF;
          end
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_fetch();
    test_priority();
    test_store();
    test_no_preempt();
    test_async_reset();
    test_lat1();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
